music_sequencer: RTL
====================

# music_sequencer

Beat sequencer and playback controller for the background-music path. It paces the 9-bit beat index into the combinational tone ROM at a fixed tempo and implements play, pause, stop, loop and mute. It registers the ROM's tone word and substitutes the silence code when playback is inactive or muted. It sits between the game-control FSM (commands) and the audio square-wave generator (tone consumer).

## Interface
- CLK_HZ, default 100_000_000: system clock frequency.
- BEAT_HZ, default 8: beats per second; TICKS = CLK_HZ/BEAT_HZ is computed at elaboration and must be ≥ 2.
- LAST_BEAT, default 127: final beat index of the song; must be < 512.
- SILENCE, default 32'd20000: tone code meaning silence.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- play  in  1  one-cycle command pulse: start, or resume from pause.
- pause  in  1  one-cycle command pulse: freeze playback.
- stop  in  1  one-cycle command pulse: abort to idle.
- loop  in  1  level: restart at beat 0 after LAST_BEAT.
- mute  in  1  level: force tone_out to SILENCE without stopping the beat clock.
- tone_in  in  32  tone word from the ROM for the current ibeat_num.
- ibeat_num  out  9  beat index driven to the ROM.
- tone_out  out  32  registered tone word for the audio generator.
- beat_tick  out  1  one-cycle strobe on every beat boundary.
- playing  out  1  high in PLAY.
- done  out  1  high in DONE.

## Operation
- Reset values: state IDLE, ibeat_num 0, divider 0, tone_out SILENCE, beat_tick 0, playing 0, done 0.
- States: IDLE, PLAY, PAUSE, DONE. Command priority within a cycle is stop > pause > play; lower-priority commands in the same cycle are ignored.
- IDLE:
  - play → PLAY with ibeat_num = 0 and divider = 0.
  - pause and stop are ignored.
- PLAY:
  - The divider (32-bit) increments each cycle.
  - When the divider reaches TICKS-1, it clears to 0 and a beat boundary occurs:
    - If ibeat_num < LAST_BEAT, ibeat_num increments.
    - If ibeat_num == LAST_BEAT and loop is 1, ibeat_num becomes 0 and the state stays PLAY.
    - If ibeat_num == LAST_BEAT and loop is 0, ibeat_num holds at LAST_BEAT and the state becomes DONE.
  - pause → PAUSE. The divider and ibeat_num are frozen; no boundary occurs in that cycle, even if the divider is at TICKS-1.
  - stop → IDLE. ibeat_num and the divider clear; no boundary occurs.
  - play is ignored (no restart).
- PAUSE:
  - play → PLAY. The divider resumes from its frozen value, so the remaining beat time is preserved.
  - stop → IDLE with clears.
- DONE:
  - play → PLAY from beat 0 with divider 0.
  - stop → IDLE with ibeat_num cleared.
- loop is sampled only at the LAST_BEAT boundary.
- Reset mid-operation returns every output to its reset value on the next edge, regardless of state.

## Timing
- beat_tick is registered. It is high for exactly one cycle: the first cycle in which the new ibeat_num is visible, including the final-beat boundary into DONE.
- playing and done are decoded from the state register. They change on the same edge as the state.
- tone_out is registered from tone_in. Its value is tone_in when (next-state logic aside) the current state is PLAY and mute is 0; otherwise it is SILENCE.
  - Latency from an ibeat_num change to the corresponding tone_out is 1 cycle.
  - Entering PAUSE, IDLE or DONE yields SILENCE on tone_out 1 cycle after the state change.
  - mute takes effect 1 cycle after it is asserted.
- Beat period in PLAY is exactly TICKS cycles. From the play pulse in IDLE, the first boundary occurs TICKS cycles after PLAY is entered.
- No combinational path from any input to any output.

## Test plan
- Parameters for all scenarios: CLK_HZ=8, BEAT_HZ=2 (TICKS=4), LAST_BEAT=3.
- Reset then play, with loop=0 and the tone ROM model attached:
  - ibeat_num steps 0,1,2,3 every 4 cycles, with beat_tick pulsing at each step.
  - After the 4th boundary: done=1, playing=0, ibeat_num stays 3, tone_out = 20000 one cycle later.
- loop=1, free run for 20 cycles: ibeat_num wraps 3→0 with no DONE; beat_tick pulses every 4 cycles without gaps.
- Pause issued on the cycle the divider equals 3, held paused for 10 cycles, then play:
  - No tick at the pause; ibeat_num is unchanged during the pause.
  - tone_out reads 20000 during the pause.
  - The next tick occurs 1 cycle after resume.
- pause, stop and play asserted together in PLAY at beat 2 → IDLE with ibeat_num=0 and no beat_tick. Then play alone while already in PLAY → ignored; the beat sequence continues.
- mute=1 mid-song → tone_out is 20000 from the next cycle while ibeat_num keeps advancing. mute=0 → tone_out equals the ROM tone for the current beat 1 cycle later.
- rst_n=0 for one cycle while in PAUSE at beat 2 → all outputs at reset values (ibeat_num 0, tone_out 20000, playing 0, done 0) on the next edge.

Source files
------------

// File: rtl/music_sequencer.sv
// Beat sequencer for the background-music path: paces the tone ROM beat index at a fixed
// tempo and gates the registered tone word with play/pause/stop/loop/mute control.
module music_sequencer #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BEAT_HZ   = 8,
    parameter int unsigned LAST_BEAT = 127,
    parameter logic [31:0] SILENCE   = 32'd20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        pause,
    input  logic        stop,
    input  logic        loop,
    input  logic        mute,
    input  logic [31:0] tone_in,
    output logic [8:0]  ibeat_num,
    output logic [31:0] tone_out,
    output logic        beat_tick,
    output logic        playing,
    output logic        done
);

    localparam int unsigned TICKS    = CLK_HZ / BEAT_HZ;
    localparam logic [31:0] TickLast = 32'(TICKS - 1);
    localparam logic [8:0]  LastBeat = 9'(LAST_BEAT);

    typedef enum logic [1:0] {StIdle, StPlay, StPause, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] div_q, div_d;
    logic [8:0]  beat_q, beat_d;
    logic [31:0] tone_q, tone_d;
    logic        tick_q, tick_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            beat_q  <= '0;
            tone_q  <= SILENCE;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            beat_q  <= beat_d;
            tone_q  <= tone_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        beat_d  = beat_q;
        tick_d  = 1'b0;
        // Tone gating looks at the current state only, so state changes show up a cycle later.
        tone_d  = (state_q == StPlay && !mute) ? tone_in : SILENCE;

        unique case (state_q)
            StIdle: begin
                if (!stop && !pause && play) begin
                    state_d = StPlay;
                    div_d   = '0;
                    beat_d  = '0;
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = StIdle;
                    div_d   = '0;
                    beat_d  = '0;
                end else if (pause) begin
                    state_d = StPause;
                end else if (div_q == TickLast) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                    if (beat_q < LastBeat) begin
                        beat_d = beat_q + 9'd1;
                    end else if (loop) begin
                        beat_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    div_d = div_q + 32'd1;
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                    div_d   = '0;
                    beat_d  = '0;
                end else if (!pause && play) begin
                    // Divider keeps its frozen value so the partial beat is preserved.
                    state_d = StPlay;
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                    div_d   = '0;
                    beat_d  = '0;
                end else if (!pause && play) begin
                    state_d = StPlay;
                    div_d   = '0;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ibeat_num = beat_q;
    assign tone_out  = tone_q;
    assign beat_tick = tick_q;
    assign playing   = (state_q == StPlay);
    assign done      = (state_q == StDone);

endmodule
